// File: rtl/lift_call_scheduler.sv
// SCAN-ordered lift call scheduler: latches floor calls, drives a stable target
// floor to the lift controller and holds the car for a fixed dwell at each stop.
module lift_call_scheduler #(
    parameter int NUM_FLOORS   = 8,
    parameter int DWELL_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] i_call_btn,
    input  logic [6:0]            i_cur_floor,
    input  logic                  i_ctl_stop,
    input  logic                  i_ctl_door,
    output logic [6:0]            o_req_floor,
    output logic [NUM_FLOORS-1:0] o_pending,
    output logic                  o_moving_up,
    output logic                  o_moving_down,
    output logic                  o_dwelling,
    output logic                  o_serviced,
    output logic [6:0]            o_serviced_floor
);

    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(32'd1);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(32'd0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_UP    = 2'd1,
        S_DOWN  = 2'd2,
        S_DWELL = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_dir;
    logic                  w_dir_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [6:0]            r_req;
    logic [6:0]            w_req_nxt;
    logic [NUM_FLOORS-1:0] r_pending;
    logic [NUM_FLOORS-1:0] w_clr;
    logic                  r_serviced;
    logic                  w_serviced_nxt;
    logic [6:0]            r_srv_floor;
    logic [6:0]            w_srv_floor_nxt;

    logic                  w_above_vld;
    logic                  w_below_vld;
    logic [6:0]            w_above;
    logic [6:0]            w_below;
    logic [NUM_FLOORS-1:0] w_cur_hot;
    logic [NUM_FLOORS-1:0] w_req_hot;
    logic                  w_at_cur;
    logic                  w_any;
    logic                  w_arrived;
    logic [6:0]            w_up_dist;
    logic [6:0]            w_dn_dist;
    logic                  w_near_up;
    logic [6:0]            w_near;

    // Nearest pending call at/above and at/below the car, plus floor one-hots.
    always_comb begin
        w_above_vld = 1'b0;
        w_above     = 7'd0;
        w_below_vld = 1'b0;
        w_below     = 7'd0;
        w_cur_hot   = {NUM_FLOORS{1'b0}};
        w_req_hot   = {NUM_FLOORS{1'b0}};
        // Descending scan leaves the lowest hit, ascending scan the highest.
        for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
            w_above     = (r_pending[f] && (7'(f) >= i_cur_floor)) ? 7'(f) : w_above;
            w_above_vld = w_above_vld | (r_pending[f] & (7'(f) >= i_cur_floor));
        end
        for (int f = 0; f < NUM_FLOORS; f++) begin
            w_below      = (r_pending[f] && (7'(f) <= i_cur_floor)) ? 7'(f) : w_below;
            w_below_vld  = w_below_vld | (r_pending[f] & (7'(f) <= i_cur_floor));
            w_cur_hot[f] = (7'(f) == i_cur_floor);
            w_req_hot[f] = (7'(f) == r_req);
        end
    end

    assign w_at_cur  = |(r_pending & w_cur_hot);
    assign w_any     = |r_pending;
    assign w_arrived = i_ctl_stop & i_ctl_door & (i_cur_floor == r_req);
    assign w_up_dist = w_above - i_cur_floor;
    assign w_dn_dist = i_cur_floor - w_below;
    assign w_near_up = w_above_vld & (~w_below_vld | (w_up_dist <= w_dn_dist));
    assign w_near    = w_near_up ? w_above : w_below;

    // Next-state, target floor, clear mask and service pulse.
    always_comb begin
        w_state_nxt     = r_state;
        w_dir_nxt       = r_dir;
        w_cnt_nxt       = r_cnt;
        w_req_nxt       = r_req;
        w_clr           = {NUM_FLOORS{1'b0}};
        w_serviced_nxt  = 1'b0;
        w_srv_floor_nxt = r_srv_floor;
        case (r_state)
            S_IDLE: begin
                if (w_at_cur && w_arrived) begin
                    w_clr           = w_cur_hot;
                    w_serviced_nxt  = 1'b1;
                    w_srv_floor_nxt = i_cur_floor;
                    w_cnt_nxt       = DWELL_LOAD;
                    w_state_nxt     = S_DWELL;
                end else if (w_any) begin
                    w_req_nxt = w_near;
                    if (w_near > i_cur_floor) begin
                        w_state_nxt = S_UP;
                        w_dir_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_DOWN;
                        w_dir_nxt   = 1'b0;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_UP: begin
                if (w_arrived) begin
                    w_clr           = w_req_hot;
                    w_serviced_nxt  = 1'b1;
                    w_srv_floor_nxt = r_req;
                    w_cnt_nxt       = DWELL_LOAD;
                    w_state_nxt     = S_DWELL;
                end else if (w_above_vld) begin
                    w_req_nxt = w_above;
                end else if (w_any) begin
                    w_req_nxt   = w_below;
                    w_dir_nxt   = 1'b0;
                    w_state_nxt = S_DOWN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DOWN: begin
                if (w_arrived) begin
                    w_clr           = w_req_hot;
                    w_serviced_nxt  = 1'b1;
                    w_srv_floor_nxt = r_req;
                    w_cnt_nxt       = DWELL_LOAD;
                    w_state_nxt     = S_DWELL;
                end else if (w_below_vld) begin
                    w_req_nxt = w_below;
                end else if (w_any) begin
                    w_req_nxt   = w_above;
                    w_dir_nxt   = 1'b1;
                    w_state_nxt = S_UP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DWELL: begin
                // A call at the current floor is absorbed while the doors are open.
                w_clr     = w_cur_hot;
                w_req_nxt = i_cur_floor;
                if (r_cnt != CNT_ZERO) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end else if (r_dir && w_above_vld) begin
                    w_req_nxt   = w_above;
                    w_dir_nxt   = 1'b1;
                    w_state_nxt = S_UP;
                end else if (w_below_vld) begin
                    w_req_nxt   = w_below;
                    w_dir_nxt   = 1'b0;
                    w_state_nxt = S_DOWN;
                end else if (w_above_vld) begin
                    w_req_nxt   = w_above;
                    w_dir_nxt   = 1'b1;
                    w_state_nxt = S_UP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_dir       <= 1'b1;
            r_cnt       <= CNT_ZERO;
            r_req       <= 7'd0;
            r_pending   <= {NUM_FLOORS{1'b0}};
            r_serviced  <= 1'b0;
            r_srv_floor <= 7'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_dir       <= w_dir_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req       <= w_req_nxt;
            r_pending   <= (r_pending | i_call_btn) & ~w_clr;
            r_serviced  <= w_serviced_nxt;
            r_srv_floor <= w_srv_floor_nxt;
        end
    end

    assign o_req_floor      = r_req;
    assign o_pending        = r_pending;
    assign o_moving_up      = (r_state == S_UP);
    assign o_moving_down    = (r_state == S_DOWN);
    assign o_dwelling       = (r_state == S_DWELL);
    assign o_serviced       = r_serviced;
    assign o_serviced_floor = r_srv_floor;

endmodule
